// File: rtl/ibex_rf_wr_arbiter.sv
// Register-file write-port arbiter: LSU loads always win, colliding ID/EX writes park in an in-order FIFO.
// Optional collision counter enabled by defining IBEX_RF_WR_ARB_PERF_EN.
module ibex_rf_wr_arbiter #(
    parameter int unsigned Depth = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        id_we_i,
    input  logic [4:0]  id_waddr_i,
    input  logic [31:0] id_wdata_i,
    output logic        id_ready_o,
    input  logic        lsu_we_i,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [4:0]  rd_raddr_a_i,
    input  logic [4:0]  rd_raddr_b_i,
    output logic        rd_hazard_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        buf_empty_o,
    output logic [15:0] collision_cnt_o
);
    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = PW + 1;

    logic [Depth-1:0][4:0]  addr_q, addr_d;
    logic [Depth-1:0][31:0] data_q, data_d;
    logic [Depth-1:0]       valid_q, valid_d, kill_q, kill_d;
    logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]          count_q, count_d;

    logic id_wr, nonempty, pop, push, bypass;

    assign id_wr       = id_we_i && (id_waddr_i != 5'd0);
    assign nonempty    = (count_q != '0);
    assign id_ready_o  = (count_q < CW'(Depth));
    assign buf_empty_o = ~nonempty;
    assign pop         = ~lsu_we_i && nonempty;
    assign bypass      = ~lsu_we_i && ~nonempty && id_wr;
    assign push        = id_wr && id_ready_o && ~bypass;

    always_comb begin
        valid_d = valid_q;
        kill_d  = kill_q;
        addr_d  = addr_q;
        data_d  = data_q;
        // A load to R supersedes any parked older write to R, so that write must never land.
        if (lsu_we_i) begin
            for (int i = 0; i < Depth; i++) begin
                if (valid_q[i] && (addr_q[i] == lsu_waddr_i)) kill_d[i] = 1'b1;
            end
        end
        if (pop) begin
            valid_d[rptr_q] = 1'b0;
            kill_d[rptr_q]  = 1'b0;
        end
        if (push) begin
            valid_d[wptr_q] = 1'b1;
            kill_d[wptr_q]  = 1'b0;
            addr_d[wptr_q]  = id_waddr_i;
            data_d[wptr_q]  = id_wdata_i;
        end
    end

    always_comb begin
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= '0;
            kill_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            kill_q  <= kill_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = 32'd0;
        if (lsu_we_i) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = lsu_waddr_i;
            rf_wdata_o = lsu_wdata_i;
        end else if (nonempty) begin
            rf_we_o    = ~kill_q[rptr_q];
            rf_waddr_o = addr_q[rptr_q];
            rf_wdata_o = data_q[rptr_q];
        end else if (id_wr) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = id_waddr_i;
            rf_wdata_o = id_wdata_i;
        end
    end

    // Parked entries never hold x0, so x0 reads cannot match.
    always_comb begin
        rd_hazard_o = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (valid_q[i] && !kill_q[i] &&
                ((addr_q[i] == rd_raddr_a_i) || (addr_q[i] == rd_raddr_b_i)))
                rd_hazard_o = 1'b1;
        end
    end

`ifdef IBEX_RF_WR_ARB_PERF_EN
    logic        collision;
    logic [15:0] coll_cnt_q, coll_cnt_d;

    assign collision = lsu_we_i && (nonempty || id_wr);

    always_comb begin
        coll_cnt_d = coll_cnt_q;
        if (collision && (coll_cnt_q != 16'hFFFF)) coll_cnt_d = coll_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) coll_cnt_q <= 16'd0;
        else         coll_cnt_q <= coll_cnt_d;
    end

    assign collision_cnt_o = coll_cnt_q;
`else
    assign collision_cnt_o = 16'h0000;
`endif

    a_we_nonzero : assert property (@(posedge clk_i) disable iff (!rst_ni)
        rf_we_o |-> (rf_waddr_o != 5'd0));
    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        push |-> (count_q < CW'(Depth)));
    a_id_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (id_we_i && !id_ready_o) |=> (id_we_i && $stable(id_waddr_i) && $stable(id_wdata_i)));

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Directed bench for ibex_rf_wr_arbiter (Depth=2): bypass, collision, full, kill, hazard/x0, reset.
module tb_ibex_rf_wr_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        id_we_i, lsu_we_i;
    logic [4:0]  id_waddr_i, lsu_waddr_i, rd_raddr_a_i, rd_raddr_b_i;
    logic [31:0] id_wdata_i, lsu_wdata_i;
    logic        id_ready_o, rd_hazard_o, rf_we_o, buf_empty_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [15:0] collision_cnt_o;

    int total = 0;
    int bad   = 0;

`ifdef IBEX_RF_WR_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    ibex_rf_wr_arbiter #(.Depth(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_we_i(id_we_i), .id_waddr_i(id_waddr_i), .id_wdata_i(id_wdata_i), .id_ready_o(id_ready_o),
        .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .rd_raddr_a_i(rd_raddr_a_i), .rd_raddr_b_i(rd_raddr_b_i), .rd_hazard_o(rd_hazard_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .buf_empty_o(buf_empty_o), .collision_cnt_o(collision_cnt_o)
    );

    // Advance past the next rising edge; inputs are then changed and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        id_we_i = 0; id_waddr_i = 0; id_wdata_i = 0;
        lsu_we_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
        rd_raddr_a_i = 0; rd_raddr_b_i = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 0;
        tick();
        rst_ni = 1;
        tick();
    endtask

    task automatic id_drive(input logic [4:0] a, input logic [31:0] d);
        id_we_i = 1; id_waddr_i = a; id_wdata_i = d;
    endtask

    task automatic lsu_drive(input logic [4:0] a, input logic [31:0] d);
        lsu_we_i = 1; lsu_waddr_i = a; lsu_wdata_i = d;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        total++; if (id_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", id_ready_o); end
        total++; if (buf_empty_o !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", buf_empty_o); end
        total++; if (rd_hazard_o !== 1'b0) begin bad++; $display("FAIL rst_hazard got=%b exp=0", rd_hazard_o); end
        total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", rf_we_o); end
        total++; if (collision_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", collision_cnt_o); end
    endtask

    task automatic test_bypass();
        do_reset();
        id_drive(5'd5, 32'hA5A5_0001);
        #2;
        total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd5, 32'hA5A5_0001})
            begin bad++; $display("FAIL bypass_out got=%b/%0d/%h exp=1/5/a5a50001", rf_we_o, rf_waddr_o, rf_wdata_o); end
        tick();
        idle();
        #2;
        total++; if (buf_empty_o !== 1'b1) begin bad++; $display("FAIL bypass_empty got=%b exp=1", buf_empty_o); end
        total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL bypass_idle_we got=%b exp=0", rf_we_o); end
    endtask

    task automatic test_collision();
        do_reset();
        id_drive(5'd7, 32'h11);
        lsu_drive(5'd9, 32'h22);
        #2;
        total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd9, 32'h22})
            begin bad++; $display("FAIL coll_lsu got=%b/%0d/%h exp=1/9/22", rf_we_o, rf_waddr_o, rf_wdata_o); end
        tick();
        idle();
        #2;
        total++; if (buf_empty_o !== 1'b0) begin bad++; $display("FAIL coll_parked got=%b exp=0", buf_empty_o); end
        total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd7, 32'h11})
            begin bad++; $display("FAIL coll_drain got=%b/%0d/%h exp=1/7/11", rf_we_o, rf_waddr_o, rf_wdata_o); end
        total++; if (collision_cnt_o !== (PERF ? 16'd1 : 16'd0))
            begin bad++; $display("FAIL coll_cnt got=%0d exp=%0d", collision_cnt_o, PERF ? 1 : 0); end
        tick();
        total++; if (buf_empty_o !== 1'b1) begin bad++; $display("FAIL coll_empty got=%b exp=1", buf_empty_o); end
    endtask

    task automatic test_full();
        do_reset();
        // c0, c1: x1, x2 park behind LSU writes
        lsu_drive(5'd20, 32'h20); id_drive(5'd1, 32'h101); #2;
        total++; if (id_ready_o !== 1'b1) begin bad++; $display("FAIL full_rdy0 got=%b exp=1", id_ready_o); end
        tick();
        lsu_drive(5'd21, 32'h21); id_drive(5'd2, 32'h102); #2;
        total++; if (id_ready_o !== 1'b1) begin bad++; $display("FAIL full_rdy1 got=%b exp=1", id_ready_o); end
        tick();
        // c2, c3: full, x3 held
        lsu_drive(5'd22, 32'h22); id_drive(5'd3, 32'h103); #2;
        total++; if (id_ready_o !== 1'b0) begin bad++; $display("FAIL full_rdy2 got=%b exp=0", id_ready_o); end
        tick();
        lsu_drive(5'd23, 32'h23); #2;
        total++; if (id_ready_o !== 1'b0) begin bad++; $display("FAIL full_rdy3 got=%b exp=0", id_ready_o); end
        tick();
        // c4: LSU stops, x1 drains, still full this cycle
        lsu_we_i = 0; #2;
        total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd1, 32'h101})
            begin bad++; $display("FAIL full_pop1 got=%b/%0d/%h exp=1/1/101", rf_we_o, rf_waddr_o, rf_wdata_o); end
        total++; if (id_ready_o !== 1'b0) begin bad++; $display("FAIL full_rdy4 got=%b exp=0", id_ready_o); end
        total++; if (collision_cnt_o !== (PERF ? 16'd4 : 16'd0))
            begin bad++; $display("FAIL full_cnt got=%0d exp=%0d", collision_cnt_o, PERF ? 4 : 0); end
        tick();
        // c5: x2 drains, ready back, x3 enqueues
        #2;
        total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd2, 32'h102})
            begin bad++; $display("FAIL full_pop2 got=%b/%0d/%h exp=1/2/102", rf_we_o, rf_waddr_o, rf_wdata_o); end
        total++; if (id_ready_o !== 1'b1) begin bad++; $display("FAIL full_rdy5 got=%b exp=1", id_ready_o); end
        tick();
        idle(); #2;
        total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd3, 32'h103})
            begin bad++; $display("FAIL full_pop3 got=%b/%0d/%h exp=1/3/103", rf_we_o, rf_waddr_o, rf_wdata_o); end
        tick();
        total++; if (buf_empty_o !== 1'b1) begin bad++; $display("FAIL full_empty got=%b exp=1", buf_empty_o); end
    endtask

    task automatic test_kill();
        do_reset();
        id_drive(5'd3, 32'hDEAD); lsu_drive(5'd10, 32'h1);
        tick();
        idle(); lsu_drive(5'd3, 32'hBEEF); rd_raddr_a_i = 5'd3; #2;
        total++; if (rd_hazard_o !== 1'b1) begin bad++; $display("FAIL kill_haz_pre got=%b exp=1", rd_hazard_o); end
        total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd3, 32'hBEEF})
            begin bad++; $display("FAIL kill_lsu got=%b/%0d/%h exp=1/3/beef", rf_we_o, rf_waddr_o, rf_wdata_o); end
        tick();
        lsu_we_i = 0; #2;
        total++; if (rd_hazard_o !== 1'b0) begin bad++; $display("FAIL kill_haz_post got=%b exp=0", rd_hazard_o); end
        total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL kill_pop_we got=%b exp=0", rf_we_o); end
        total++; if (buf_empty_o !== 1'b0) begin bad++; $display("FAIL kill_occupied got=%b exp=0", buf_empty_o); end
        tick();
        total++; if (buf_empty_o !== 1'b1) begin bad++; $display("FAIL kill_empty got=%b exp=1", buf_empty_o); end
    endtask

    task automatic test_hazard_x0();
        do_reset();
        id_drive(5'd12, 32'hC0C0); lsu_drive(5'd10, 32'h1);
        tick();
        idle(); lsu_drive(5'd11, 32'h2); rd_raddr_a_i = 5'd12; #2;
        total++; if (rd_hazard_o !== 1'b1) begin bad++; $display("FAIL haz_a got=%b exp=1", rd_hazard_o); end
        rd_raddr_a_i = 5'd0; rd_raddr_b_i = 5'd12; #1;
        total++; if (rd_hazard_o !== 1'b1) begin bad++; $display("FAIL haz_b got=%b exp=1", rd_hazard_o); end
        rd_raddr_b_i = 5'd0; #1;
        total++; if (rd_hazard_o !== 1'b0) begin bad++; $display("FAIL haz_x0 got=%b exp=0", rd_hazard_o); end
        id_drive(5'd0, 32'hFFFF); #1;
        total++; if (id_ready_o !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", id_ready_o); end
        tick();
        // x0 dropped: only x12 remains and drains, then empty
        idle(); #2;
        total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd12, 32'hC0C0})
            begin bad++; $display("FAIL x0_pop got=%b/%0d/%h exp=1/12/c0c0", rf_we_o, rf_waddr_o, rf_wdata_o); end
        tick();
        total++; if (buf_empty_o !== 1'b1) begin bad++; $display("FAIL x0_empty got=%b exp=1", buf_empty_o); end
        id_drive(5'd0, 32'hFFFF); #1;
        total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL x0_bypass_we got=%b exp=0", rf_we_o); end
        tick();
        idle(); #1;
        total++; if (buf_empty_o !== 1'b1) begin bad++; $display("FAIL x0_no_enq got=%b exp=1", buf_empty_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        id_drive(5'd4, 32'h44); lsu_drive(5'd20, 32'h1);
        tick();
        id_drive(5'd5, 32'h55); lsu_drive(5'd21, 32'h2);
        tick();
        idle(); lsu_drive(5'd22, 32'h3); #2;
        total++; if (id_ready_o !== 1'b0) begin bad++; $display("FAIL rmid_full got=%b exp=0", id_ready_o); end
        rst_ni = 0; idle(); #1;
        total++; if (id_ready_o !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", id_ready_o); end
        total++; if (buf_empty_o !== 1'b1) begin bad++; $display("FAIL rmid_empty got=%b exp=1", buf_empty_o); end
        tick();
        rst_ni = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            rd_raddr_a_i = 5'd4; rd_raddr_b_i = 5'd5; #1;
            total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL rmid_ghost_we c%0d got=%b exp=0", i, rf_we_o); end
            total++; if (rd_hazard_o !== 1'b0) begin bad++; $display("FAIL rmid_haz c%0d got=%b exp=0", i, rd_hazard_o); end
        end
    endtask

    initial begin
        rst_ni = 0;
        idle();
        test_reset();
        test_bypass();
        test_collision();
        test_full();
        test_kill();
        test_hazard_x0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/ibex_rf_wr_arbiter.md
Name: ibex_rf_wr_arbiter

Overview:
- Arbitrates the single register-file write port between ID/EX results and LSU load data.
- Sits between the writeback stage outputs and the register file.
- Load data from the LSU cannot be stalled, so it always wins the port.
- A colliding ID/EX write is parked in a small in-order FIFO and drained on free cycles. Read-hazard flags for parked writes are returned to the ID stage.

Parameters:
- Depth, 2, number of ID/EX write buffer entries; power of two, >=2.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- id_we_i  input  1  ID/EX write request
- id_waddr_i  input  5  ID/EX destination register
- id_wdata_i  input  32  ID/EX write data
- id_ready_o  output  1  ID/EX write can be accepted this cycle
- lsu_we_i  input  1  LSU load write (cannot be back-pressured)
- lsu_waddr_i  input  5  LSU destination register
- lsu_wdata_i  input  32  LSU load data
- rd_raddr_a_i  input  5  ID read port A address
- rd_raddr_b_i  input  5  ID read port B address
- rd_hazard_o  output  1  a read address matches a parked, not-yet-written entry
- rf_we_o  output  1  register-file write enable
- rf_waddr_o  output  5  register-file write address
- rf_wdata_o  output  32  register-file write data
- buf_empty_o  output  1  no valid or killed entries held
- collision_cnt_o  output  16  collision counter (optional feature)

Behaviour:
- Reset: FIFO empty (count 0, pointers 0, all valid/kill bits 0).
  - id_ready_o=1, buf_empty_o=1, rd_hazard_o=0, collision_cnt_o=0.
  - rf_we_o=0 while id_we_i=lsu_we_i=0.
  - Reset mid-operation discards all parked entries; their writes never occur.
- id_ready_o = (count < Depth). Registered state only; no combinational path from lsu_we_i or id_we_i.
- Writes with id_waddr_i=0 are accepted (ready honoured) but dropped: never enqueued, never output.
- Port selection each cycle, in priority order:
  1. lsu_we_i=1: output LSU address/data, rf_we_o=1.
  2. Else FIFO non-empty: pop head. rf_we_o=1 if head not killed; a killed head pops with rf_we_o=0.
  3. Else id_we_i & waddr!=0: direct bypass, zero latency, nothing enqueued.
- Enqueue: id_we_i & id_ready_o & waddr!=0 and the bypass path not taken. Entry is written at the tail at the clock edge.
- Push and pop in the same cycle are legal. Count is unchanged; pointers wrap modulo Depth.
- In-order drain: entries leave in arrival order, one per cycle, only in cycles with lsu_we_i=0.
- Write ordering contract:
  - The pipeline does not let a younger instruction writing a load's rd enter while that load is outstanding.
  - Therefore lsu_we_i with lsu_waddr_i=R sets the kill bit on every valid entry with address R, in the same edge.
  - Killed entries still occupy slots until popped.
- rd_hazard_o: OR over non-killed valid entries of (addr == rd_raddr_a_i or addr == rd_raddr_b_i). Address 0 never hazards. Combinational from state and read addresses.
- buf_empty_o = (count == 0).
- Collision: lsu_we_i=1 and (FIFO non-empty or id_we_i with waddr!=0).
- Assertions:
  - rf_we_o implies rf_waddr_o != 0.
  - No enqueue when count == Depth.
  - id_we_i held with stable address/data while id_ready_o=0.

Optional Feature:
- IBEX_RF_WR_ARB_PERF_EN defined:
  - collision_cnt_o increments by 1 on every collision cycle and saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: collision_cnt_o tied to 16'h0000 and no counter flops are synthesized.

Test Plan:
- Bypass: FIFO empty, id_we_i=1, waddr=5, wdata=32'hA5A5_0001, lsu_we_i=0 -> same cycle rf_we_o=1, waddr 5, data 32'hA5A5_0001; buf_empty_o stays 1.
- Collision: id write x7=32'h11 with lsu write x9=32'h22 in cycle N -> cycle N writes x9=32'h22 and parks x7. Cycle N+1 (no LSU) writes x7=32'h11; collision_cnt_o=1 with macro, 0 without.
- Full: Depth=2, LSU writes 4 consecutive cycles while ID presents x1..x4 -> x1,x2 accepted, id_ready_o=0 from cycle 2. After LSU stops, x1 then x2 drain; id_ready_o returns to 1 one cycle after first pop.
- Kill: park x3=32'hDEAD, then lsu write x3=32'hBEEF -> RF gets x3=32'hBEEF; the parked entry pops with rf_we_o=0; rd_hazard_o for raddr 3 is 0 after the kill edge.
- Hazard/x0: park x12, rd_raddr_a_i=12 -> rd_hazard_o=1. id write x0=32'hFFFF -> accepted, rf_we_o=0, count unchanged.
- Reset: rst_ni low with 2 entries parked -> count 0, id_ready_o=1, buf_empty_o=1; no parked write appears after release.
